// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with registered read data, registered
// occupancy flags and sticky overflow/underflow error flags.
module sync_fifo_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned AF_LVL = 6,
    parameter int unsigned AE_LVL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inp_d,
    input  logic              write_flg,
    input  logic              read_flg,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DATA_W-1:0] out_d,
    output logic              out_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic              rd_ok;
    logic              wr_ok;
    logic              rd_en;
    logic              wr_en;
    logic              overflow_set;
    logic              underflow_set;
    logic [CNT_W-1:0]  count_next;

    // Accept/refuse decisions; flush overrides both requests and suppresses error events.
    always_comb begin
        rd_ok         = read_flg & ~empty;
        wr_ok         = write_flg & (~full | rd_ok);
        rd_en         = rd_ok & ~flush;
        wr_en         = wr_ok & ~flush;
        overflow_set  = write_flg & ~wr_ok & ~flush;
        underflow_set = read_flg & empty & ~flush;
        count_next    = count;
        if (flush) begin
            count_next = '0;
        end else if (wr_en && !rd_en) begin
            count_next = count + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Flags are derived from the next count so they always match the count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            out_d        <= '0;
            out_valid    <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_next;
            full         <= (count_next == CNT_W'(DEPTH));
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= CNT_W'(AF_LVL));
            almost_empty <= (count_next <= CNT_W'(AE_LVL));
            out_valid    <= rd_en;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                    out_d  <= mem[rd_ptr];
                end
                // Set wins over clear so an event in the clearing cycle is not lost.
                overflow  <= (overflow & ~clr_err) | overflow_set;
                underflow <= (underflow & ~clr_err) | underflow_set;
            end
        end
    end

    // Storage is deliberately not reset; the reset term blocks a write at a reset edge.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= inp_d;
        end
    end

endmodule
